// File: rtl/fp_adder_pkg.sv
// Shared definitions for the FP adder result path.
//   FP_WIDTH/FP_EXP_W/FP_MAN_W : half-precision word layout (sign | exp | mantissa)
//   col_state_t                : result collector FSM encoding
//   fp_exp / fp_man            : field extraction for default-width words
package fp_adder_pkg;

   localparam int FP_WIDTH = 16;
   localparam int FP_EXP_W = 5;
   localparam int FP_MAN_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_PUSH  = 2'd3
   } col_state_t;

   function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [FP_WIDTH-1:0] w);
      return w[FP_WIDTH-2 -: FP_EXP_W];
   endfunction

   function automatic logic [FP_MAN_W-1:0] fp_man(input logic [FP_WIDTH-1:0] w);
      return w[FP_MAN_W-1:0];
   endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous first-word-fall-through FIFO for collected result words.
//   clk_in, rst_in : clock, async active-low reset
//   wr_en, wr_data : push (ignored when full)
//   rd_en          : pop (ignored when empty)
//   rd_data        : head entry, valid whenever empty=0
//   empty, full    : occupancy status
module collector_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Power-of-two depth: pointers wrap naturally.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fp_result_collector.sv
// Collects serial FP adder results, deserialises them MSB-first and queues
// them for a valid/ready consumer with NaN/Inf/zero decode of the head word.
//   clk_in, rst_in     : clock, async active-low reset
//   output_rdy         : upstream has a result to shift out
//   serial_out         : upstream serial result bit
//   output_read_in     : read strobe to upstream, high through WAIT and SHIFT
//   res_data/res_valid : FIFO head word and its valid
//   res_ready          : consumer pop
//   res_is_nan/inf/zero: head classification, 0 when nothing is valid
//   fifo_full          : all entries occupied
//   words_rx           : words pushed since reset, wrapping
//
// state | meaning
// IDLE  | waiting for output_rdy with FIFO space
// WAIT  | strobe raised, upstream latency before first bit
// SHIFT | sampling WIDTH bits MSB-first
// PUSH  | writing the assembled word into the FIFO
module fp_result_collector
   import fp_adder_pkg::*;
#(
   parameter int WIDTH           = FP_WIDTH,
   parameter int EXP_W           = FP_EXP_W,
   parameter int MAN_W           = FP_MAN_W,
   parameter int DEPTH           = 4,
   parameter int FIRST_BIT_DELAY = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             output_rdy,
   input  logic             serial_out,
   output logic             output_read_in,
   output logic [WIDTH-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_is_nan,
   output logic             res_is_inf,
   output logic             res_is_zero,
   output logic             fifo_full,
   output logic [15:0]      words_rx
);

   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int DLY_W = (FIRST_BIT_DELAY > 1) ? $clog2(FIRST_BIT_DELAY + 1) : 1;

   col_state_t       state;
   col_state_t       state_nxt;
   logic [BIT_W-1:0] bit_cnt;
   logic [DLY_W-1:0] wait_cnt;
   logic [WIDTH-1:0] sreg;
   logic             fifo_wr;
   logic             fifo_empty;
   logic [WIDTH-1:0] head;
   logic [EXP_W-1:0] head_exp;
   logic [MAN_W-1:0] head_man;

   always_comb begin
      state_nxt      = state;
      output_read_in = 1'b0;
      fifo_wr        = 1'b0;
      case (state)
         // Full FIFO leaves output_rdy pending upstream rather than dropping it.
         ST_IDLE:  if (output_rdy && !fifo_full) state_nxt = ST_WAIT;
         ST_WAIT: begin
            output_read_in = 1'b1;
            if (wait_cnt == '0) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            output_read_in = 1'b1;
            if (bit_cnt == BIT_W'(WIDTH - 1)) state_nxt = ST_PUSH;
         end
         ST_PUSH: begin
            fifo_wr   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         wait_cnt <= '0;
         sreg     <= '0;
         words_rx <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               bit_cnt  <= '0;
               wait_cnt <= DLY_W'(FIRST_BIT_DELAY - 1);
            end
            ST_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            ST_SHIFT: begin
               sreg    <= {sreg[WIDTH-2:0], serial_out};
               bit_cnt <= bit_cnt + 1'b1;
            end
            ST_PUSH: begin
               words_rx <= words_rx + 1'b1;
               bit_cnt  <= '0;
            end
            default: ;
         endcase
      end
   end

   collector_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .wr_en   (fifo_wr),
      .wr_data (sreg),
      .rd_en   (res_ready && res_valid),
      .rd_data (head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Head is gated so a stale entry never shows through, and a zeroed
   // empty head does not read as a zero result.
   assign res_valid   = !fifo_empty;
   assign res_data    = res_valid ? head : '0;
   assign head_exp    = res_data[WIDTH-2 -: EXP_W];
   assign head_man    = res_data[MAN_W-1:0];
   assign res_is_nan  = res_valid && (&head_exp) && (head_man != '0);
   assign res_is_inf  = res_valid && (&head_exp) && (head_man == '0);
   assign res_is_zero = res_valid && (head_exp == '0) && (head_man == '0);

endmodule

// File: tb/tb_fp_result_collector.sv
module tb_fp_result_collector;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        output_rdy;
   logic        serial_out;
   logic        output_read_in;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        res_is_nan;
   logic        res_is_inf;
   logic        res_is_zero;
   logic        fifo_full;
   logic [15:0] words_rx;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb_q[$];
   logic [15:0] words_exp = 16'd0;

   always #5 clk_in = ~clk_in;

   fp_result_collector dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .output_rdy     (output_rdy),
      .serial_out     (serial_out),
      .output_read_in (output_read_in),
      .res_data       (res_data),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_is_nan     (res_is_nan),
      .res_is_inf     (res_is_inf),
      .res_is_zero    (res_is_zero),
      .fifo_full      (fifo_full),
      .words_rx       (words_rx)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Upstream model: first bit valid FIRST_BIT_DELAY(=1) cycle after strobe rises.
   task automatic send_word(input logic [15:0] w, input bit pulse);
      int n;
      sb_q.push_back(w);
      output_rdy = 1'b1;
      if (pulse) begin
         @(posedge clk_in); #1 output_rdy = 1'b0;
      end
      n = 0;
      while (!output_read_in && n < 300) begin
         @(negedge clk_in);
         n++;
      end
      chk("read_start", {31'd0, output_read_in}, 32'd1);
      output_rdy = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk_in); #1 serial_out = w[15-i];
      end
      repeat (2) @(posedge clk_in);
      #1;
      words_exp = words_exp + 16'd1;
      chk("words_rx", {16'd0, words_rx}, {16'd0, words_exp});
   endtask

   task automatic check_head(input string tag);
      logic [15:0] w;
      logic [4:0]  e;
      logic [9:0]  m;
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      w = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
      e = w[14:10];
      m = w[9:0];
      chk({tag, "_data"}, {16'd0, res_data}, {16'd0, w});
      chk({tag, "_nan"},  {31'd0, res_is_nan},  {31'd0, (e == 5'h1f) && (m != 10'd0)});
      chk({tag, "_inf"},  {31'd0, res_is_inf},  {31'd0, (e == 5'h1f) && (m == 10'd0)});
      chk({tag, "_zero"}, {31'd0, res_is_zero}, {31'd0, (e == 5'd0) && (m == 10'd0)});
   endtask

   task automatic pop_check(input string tag);
      @(negedge clk_in);
      check_head(tag);
      res_ready = 1'b1;
      @(posedge clk_in); #1 res_ready = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      @(negedge clk_in);
      chk({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
      chk({tag, "_data"},  {16'd0, res_data},  32'd0);
      chk({tag, "_flags"}, {29'd0, res_is_nan, res_is_inf, res_is_zero}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst_in = 1'b0; output_rdy = 1'b0; serial_out = 1'b0; res_ready = 1'b0;
      #1;
      chk("rst_read_in", {31'd0, output_read_in}, 32'd0);
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      chk("rst_words", {16'd0, words_rx}, 32'd0);
      check_empty("rst");
      @(negedge clk_in); rst_in = 1'b1;
      @(negedge clk_in);

      // 1: single word, latency counted from the sampling edge
      n = 0;
      fork
         send_word(16'h3C00, 1'b0);
         begin
            while (n < 40) begin
               @(posedge clk_in); #1 n++;
               if (res_valid) break;
            end
         end
      join
      chk("latency", n, 32'd19);
      pop_check("t1");
      check_empty("t1_empty");

      // 2: special values
      send_word(16'h7C00, 1'b0);
      send_word(16'hFE00, 1'b0);
      send_word(16'h8000, 1'b0);
      pop_check("t2_inf");
      pop_check("t2_nan");
      pop_check("t2_zero");
      check_empty("t2_empty");

      // 3: backpressure with five offered results
      send_word(16'h0001, 1'b0);
      send_word(16'h0002, 1'b0);
      send_word(16'h0003, 1'b0);
      send_word(16'h0004, 1'b0);
      @(negedge clk_in);
      chk("t3_full", {31'd0, fifo_full}, 32'd1);
      fork
         send_word(16'h0005, 1'b0);
         begin
            repeat (5) @(negedge clk_in);
            chk("t3_held", {31'd0, output_read_in}, 32'd0);
            chk("t3_still_full", {31'd0, fifo_full}, 32'd1);
            check_head("t3_pop1");
            res_ready = 1'b1;
            @(posedge clk_in); #1 res_ready = 1'b0;
         end
      join
      @(negedge clk_in);
      chk("t3_refull", {31'd0, fifo_full}, 32'd1);
      for (int i = 0; i < 4; i++) pop_check("t3_drain");
      check_empty("t3_empty");

      // 4: pop coinciding with push at count DEPTH-1
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      send_word(16'h3333, 1'b0);
      fork
         send_word(16'h4444, 1'b0);
         begin
            n = 0;
            while (!output_read_in && n < 100) begin @(negedge clk_in); n++; end
            n = 0;
            while (output_read_in && n < 100) begin @(negedge clk_in); n++; end
            check_head("t4_pop_at_push");
            res_ready = 1'b1;
            @(posedge clk_in); #1 res_ready = 1'b0;
         end
      join
      @(negedge clk_in);
      chk("t4_not_full", {31'd0, fifo_full}, 32'd0);
      for (int i = 0; i < 3; i++) pop_check("t4_drain");
      check_empty("t4_empty");

      // 5: reset in the middle of SHIFT
      send_word(16'h1234, 1'b0);
      output_rdy = 1'b1;
      n = 0;
      while (!output_read_in && n < 100) begin @(negedge clk_in); n++; end
      output_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_in); #1 serial_out = ~serial_out;
      end
      #2 rst_in = 1'b0;
      #1;
      chk("t5_read_in", {31'd0, output_read_in}, 32'd0);
      chk("t5_valid", {31'd0, res_valid}, 32'd0);
      chk("t5_words", {16'd0, words_rx}, 32'd0);
      sb_q.delete();
      words_exp = 16'd0;
      @(negedge clk_in); rst_in = 1'b1;
      @(negedge clk_in);
      send_word(16'h4200, 1'b0);
      pop_check("t5_after");
      check_empty("t5_empty");

      // 6: one-cycle output_rdy pulse
      send_word(16'hABCD, 1'b1);
      pop_check("t6");
      check_empty("t6_empty");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
